// File: rtl/pkt_handler_pkg.sv
// Shared constants, FSM state encoding and deserialiser field bundle
// for the platoon packet handler.
package pkt_handler_pkg;

  localparam int unsigned FRAME_BYTES = 8;
  localparam int unsigned CNT_W       = $clog2(FRAME_BYTES);
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned DATA_W      = 16;

  localparam logic [BYTE_W-1:0] PREAMBLE   = 8'h96;
  localparam logic [BYTE_W-1:0] FRAME_TYPE = 8'h0F;
  localparam logic [BYTE_W-1:0] KILL_BYTE  = 8'hFF;
  localparam logic [DATA_W-1:0] TRAILER    = 16'h3362;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  // Running per-field results plus the raw bytes that are checked at B7.
  typedef struct packed {
    logic              pre_ok;
    logic              type_ok;
    logic              kill_ok;
    logic              trl_hi_ok;
    logic [BYTE_W-1:0] dst;
    logic [BYTE_W-1:0] src;
    logic [DATA_W-1:0] payload;
  } frame_fields_t;

endpackage

// File: rtl/pkt_deser.sv
// Byte deserialiser: tracks position within the frame and accumulates
// per-field match flags; IDs are kept raw so they are compared at B7.
module pkt_deser
  import pkt_handler_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   rx_frame,
  input  logic                accept,
  output state_t              state,
  output logic [CNT_W-1:0]    byte_cnt,
  output frame_fields_t       fields
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      fields   <= '0;
    end else if (accept) begin
      // Kill tracking restarts on B0 and must see 0xFF in every byte.
      if (state == IDLE) begin
        fields.kill_ok <= (rx_frame == KILL_BYTE);
      end else begin
        fields.kill_ok <= fields.kill_ok & (rx_frame == KILL_BYTE);
      end

      case (byte_cnt)
        CNT_W'(0): fields.pre_ok          <= (rx_frame == PREAMBLE);
        CNT_W'(1): fields.type_ok         <= (rx_frame == FRAME_TYPE);
        CNT_W'(2): fields.dst             <= rx_frame;
        CNT_W'(3): fields.src             <= rx_frame;
        CNT_W'(4): fields.payload[15:8]   <= rx_frame;
        CNT_W'(5): fields.payload[7:0]    <= rx_frame;
        CNT_W'(6): fields.trl_hi_ok       <= (rx_frame == TRAILER[15:8]);
        default: ;
      endcase

      if (byte_cnt == LAST_IDX) begin
        state    <= IDLE;
        byte_cnt <= '0;
      end else begin
        state    <= RECV;
        byte_cnt <= CNT_W'(byte_cnt + CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/pkt_handler.sv
// Packet handler top: byte handshake, end-of-frame pass/kill decision
// and the registered result outputs.
module pkt_handler
  import pkt_handler_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   prev_id,
  input  logic [BYTE_W-1:0]   veh_id,
  input  logic [BYTE_W-1:0]   rx_frame,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [DATA_W-1:0]   data,
  output logic                data_valid,
  output logic                kill
);

  state_t            state;
  logic [CNT_W-1:0]  byte_cnt;
  frame_fields_t     fields;

  logic accept_c;
  logic first_c;
  logic last_c;
  logic kill_c;
  logic pass_c;

  assign accept_c = rx_valid & rx_ready;

  pkt_deser u_deser (
    .clk      (clk),
    .rst      (rst),
    .rx_frame (rx_frame),
    .accept   (accept_c),
    .state    (state),
    .byte_cnt (byte_cnt),
    .fields   (fields)
  );

  // Decision terms fold in B7 straight from the bus on the accepting edge.
  always_comb begin
    first_c = accept_c && (state == IDLE);
    last_c  = accept_c && (state == RECV) && (byte_cnt == LAST_IDX);
    kill_c  = fields.kill_ok && (rx_frame == KILL_BYTE);
    pass_c  = fields.pre_ok && fields.type_ok && fields.trl_hi_ok
              && (fields.dst == veh_id) && (fields.src == prev_id)
              && (rx_frame == TRAILER[7:0]) && !kill_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready   <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      kill       <= 1'b0;
    end else begin
      rx_ready <= 1'b1;
      if (last_c) begin
        kill       <= kill_c;
        data_valid <= pass_c;
        if (pass_c) begin
          data <= fields.payload;
        end
      end else if (first_c) begin
        kill       <= 1'b0;
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pkt_handler.sv
// Directed bench for pkt_handler: kill, drop and pass frames, gaps,
// output hold/clear behaviour and mid-frame reset.
module tb_pkt_handler;

  logic        clk;
  logic        rst;
  logic [7:0]  prev_id;
  logic [7:0]  veh_id;
  logic [7:0]  rx_frame;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] data;
  logic        data_valid;
  logic        kill;

  int tests = 0;
  int fails = 0;

  pkt_handler dut (
    .clk        (clk),
    .rst        (rst),
    .prev_id    (prev_id),
    .veh_id     (veh_id),
    .rx_frame   (rx_frame),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .data       (data),
    .data_valid (data_valid),
    .kill       (kill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one byte from just after an edge; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    check("rx_ready_before_byte", 16'(rx_ready), 16'h0001);
    rx_frame = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_frame = 8'hFF;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bytes(input logic [63:0] frame, input int first, input int last, input int gap);
    logic [7:0] b;
    for (int i = first; i <= last; i++) begin
      b = frame[63-8*i -: 8];
      send_byte(b);
      if (i != last) idle_cycles(gap);
    end
  endtask

  task automatic send_frame(input logic [63:0] frame, input int gap);
    send_bytes(frame, 0, 7, gap);
  endtask

  initial begin
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_frame = 8'h00;
    veh_id   = 8'h01;
    prev_id  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_rx_ready", 16'(rx_ready), 16'h0000);
    check("reset_data", data, 16'h0000);
    check("reset_data_valid", 16'(data_valid), 16'h0000);
    check("reset_kill", 16'(kill), 16'h0000);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", 16'(rx_ready), 16'h0001);

    // Kill frame
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("kill_frame_kill", 16'(kill), 16'h0001);
    check("kill_frame_dv", 16'(data_valid), 16'h0000);
    check("kill_frame_data", data, 16'h0000);
    idle_cycles(3);
    check("kill_held", 16'(kill), 16'h0001);

    // Wrong destination; B0 of this frame clears kill
    send_bytes(64'h960F_0273_A752_3362, 0, 0, 0);
    check("kill_cleared_by_b0", 16'(kill), 16'h0000);
    send_bytes(64'h960F_0273_A752_3362, 1, 7, 0);
    check("bad_dst_kill", 16'(kill), 16'h0000);
    check("bad_dst_dv", 16'(data_valid), 16'h0000);
    check("bad_dst_data", data, 16'h0000);

    // Wrong source
    send_frame(64'h960F_0173_A758_3362, 0);
    check("bad_src_dv", 16'(data_valid), 16'h0000);
    check("bad_src_data", data, 16'h0000);

    // Pass frame
    send_frame(64'h960F_0100_B3C5_3362, 0);
    check("pass_dv", 16'(data_valid), 16'h0001);
    check("pass_data", data, 16'hB3C5);
    check("pass_kill", 16'(kill), 16'h0000);
    idle_cycles(4);
    check("pass_dv_held", 16'(data_valid), 16'h0001);

    // Next frame (bad trailer low byte): B0 clears dv, data holds
    send_bytes(64'h960F_0100_1234_3363, 0, 0, 0);
    check("dv_cleared_by_b0", 16'(data_valid), 16'h0000);
    check("data_held_mid_frame", data, 16'hB3C5);
    send_bytes(64'h960F_0100_1234_3363, 1, 7, 0);
    check("bad_trailer_dv", 16'(data_valid), 16'h0000);
    check("bad_trailer_data", data, 16'hB3C5);

    // Nearly-kill frame: last byte not 0xFF
    send_frame(64'hFFFF_FFFF_FFFF_FFFE, 0);
    check("near_kill_kill", 16'(kill), 16'h0000);
    check("near_kill_dv", 16'(data_valid), 16'h0000);

    // Kill ignores IDs
    veh_id  = 8'h55;
    prev_id = 8'hAA;
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("kill_other_ids", 16'(kill), 16'h0001);
    check("kill_other_ids_data", data, 16'hB3C5);
    veh_id  = 8'h01;
    prev_id = 8'h00;

    // Pass frame with rx_valid gaps (bus shows 0xFF while invalid)
    send_frame(64'h960F_0100_1122_3362, 2);
    check("gap_pass_dv", 16'(data_valid), 16'h0001);
    check("gap_pass_data", data, 16'h1122);
    check("gap_pass_kill", 16'(kill), 16'h0000);

    // Reset after B3 discards the partial frame
    send_bytes(64'h960F_0100_B3C5_3362, 0, 3, 0);
    rst = 1'b0;
    #2;
    check("midrst_rx_ready", 16'(rx_ready), 16'h0000);
    check("midrst_data", data, 16'h0000);
    check("midrst_dv", 16'(data_valid), 16'h0000);
    check("midrst_kill", 16'(kill), 16'h0000);
    idle_cycles(2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_after_release", 16'(rx_ready), 16'h0001);
    send_frame(64'h960F_0100_B3C5_3362, 0);
    check("after_rst_pass_dv", 16'(data_valid), 16'h0001);
    check("after_rst_pass_data", data, 16'hB3C5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pkt_handler.md
PKT_HANDLER -- requirements
Module: pkt_handler

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-004 prev_id  input  8  expected source ID (upstream vehicle); quasi-static.
REQ-005 veh_id  input  8  own vehicle ID; quasi-static.
REQ-006 rx_frame  input  8  received frame byte, MSB-first byte order.
REQ-007 rx_valid  input  1  rx_frame carries a valid byte this cycle.
REQ-008 rx_ready  output  1  block can accept a byte this cycle.
REQ-009 data  output  16  payload of the last passed frame.
REQ-010 data_valid  output  1  last completed frame passed all checks.
REQ-011 kill  output  1  last completed frame was the kill frame.

Function
REQ-012 A frame SHALL be 8 bytes B0..B7; a byte is accepted on a rising edge with rx_valid=1 and rx_ready=1.
REQ-013 rx_ready SHALL be 0 in reset and 1 from the first clock edge after reset release; it never deasserts mid-frame.
REQ-014 A byte counter 0..7 SHALL advance only on accepted bytes; rx_valid=0 gaps pause the frame without abort; the counter wraps 7->0 after B7.
REQ-015 Frame fields: B0 preamble 0x96; B1 type 0x0F; B2 destination ID; B3 source ID; B4:B5 payload (B4 = data[15:8]); B6:B7 trailer 0x3362.
REQ-016 Kill frame: all eight bytes 0xFF; kill check takes priority over all other checks and ignores IDs.
REQ-017 Pass frame: B0=0x96, B1=0x0F, B2=veh_id, B3=prev_id, B6:B7=0x3362; anything else that is not a kill frame is dropped.
REQ-018 On the edge accepting B7: kill<=1 for a kill frame, else 0; data_valid<=1 and data<={B4,B5} for a pass frame, else data_valid<=0 and data unchanged.
REQ-019 kill and data_valid SHALL stay stable after B7 until the edge accepting B0 of the next frame, which clears both to 0.
REQ-020 data SHALL change only on a pass frame and hold its value otherwise.
REQ-021 IDs SHALL be compared at B7 against prev_id/veh_id as sampled at that edge.
REQ-022 States: IDLE (awaiting B0), RECV (B1..B7 pending); IDLE->RECV on accepted B0; RECV->IDLE on accepted B7.
REQ-023 Pass/kill decisions MAY be accumulated per byte (running match flags) rather than buffering all 8 bytes; observable behaviour per REQ-018 is identical either way.

Reset
REQ-024 While rst=0: rx_ready=0, data=16'h0000, data_valid=0, kill=0, counter=0, state IDLE.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first accepted byte after release is B0.

Structure
REQ-026 Package pkt_handler_pkg holds: PREAMBLE=8'h96, FRAME_TYPE=8'h0F, TRAILER=16'h3362, KILL_BYTE=8'hFF, FRAME_BYTES=8, and the state enum.
REQ-027 One sub-module, pkt_deser (byte counter plus per-field match flags), is natural; the top level holds output registers and the decision logic.

Verification
REQ-028 veh_id=0x01, prev_id=0x00, frame FFFFFFFFFFFFFFFF -> after B7: kill=1, data_valid=0, data=0x0000.
REQ-029 Frame 960F0273A7523362 (destination 0x02 != veh_id) -> kill=0, data_valid=0, data unchanged.
REQ-030 Frame 960F0173A7583362 (source 0x73 != prev_id) -> data_valid=0, data unchanged.
REQ-031 Frame 960F0100B3C53362 -> data_valid=1, data=0xB3C5, kill=0; next frame's B0 clears data_valid.
REQ-032 Pass frame with rx_valid gaps between bytes -> same result as REQ-031; rst=0 asserted after B3 -> all outputs reset, and the next full pass frame passes.
